// File: rtl/bitband_pkg.sv
// Shared definitions for the Bitband effect chain: sample limits, unity gain
// and the sequential-multiplier state encoding.
package bitband_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StSat
    } state_e;

    function automatic int sample_max(input int unsigned width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sample_min(input int unsigned width);
        return -(1 << (width - 1));
    endfunction

    function automatic int unsigned unity_gain(input int unsigned frac);
        return 1 << frac;
    endfunction

endpackage

// File: rtl/sat_clip.sv
// Combinational clamp of a wide signed value into a SIGWIDTH-bit signed sample.
module sat_clip
    import bitband_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 17,
    parameter int unsigned SIGWIDTH = 8
) (
    input  logic signed [IN_WIDTH-1:0] val_i,
    output logic        [SIGWIDTH-1:0] val_o
);

    localparam logic signed [IN_WIDTH-1:0] MaxW = IN_WIDTH'(sample_max(SIGWIDTH));
    localparam logic signed [IN_WIDTH-1:0] MinW = IN_WIDTH'(sample_min(SIGWIDTH));

    always_comb begin
        if (val_i > MaxW) begin
            val_o = MaxW[SIGWIDTH-1:0];
        end else if (val_i < MinW) begin
            val_o = MinW[SIGWIDTH-1:0];
        end else begin
            val_o = val_i[SIGWIDTH-1:0];
        end
    end

endmodule

// File: rtl/drive_gain.sv
// Drive stage: ramped fixed-point gain via a shift-add multiplier, then
// floor-shift and saturate to the sample width.
module drive_gain
    import bitband_pkg::*;
#(
    parameter int unsigned SIGWIDTH  = 8,
    parameter int unsigned GAINWIDTH = 8,
    parameter int unsigned GAINFRAC  = 4,
    parameter int unsigned RAMPSTEP  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sample_clk_i,
    input  logic                 mode_i,
    input  logic [GAINWIDTH-1:0] gain_target_i,
    input  logic [SIGWIDTH-1:0]  sample_in_i,
    output logic [SIGWIDTH-1:0]  sample_out_o,
    output logic                 sample_valid_o,
    output logic                 busy_o,
    output logic                 overrun_o
);

    localparam int unsigned AccW = SIGWIDTH + GAINWIDTH + 1;
    localparam int unsigned CntW = $clog2(GAINWIDTH + 1);
    localparam logic [GAINWIDTH-1:0] Unity = GAINWIDTH'(unity_gain(GAINFRAC));
    localparam logic [GAINWIDTH-1:0] Step  = GAINWIDTH'(RAMPSTEP);

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic signed [AccW-1:0] mcand_q, mcand_d;
    logic [GAINWIDTH-1:0]   mult_q, mult_d;
    logic [GAINWIDTH-1:0]   gain_q, gain_d;
    logic [SIGWIDTH-1:0]    out_q, out_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;

    logic [GAINWIDTH-1:0]   gain_diff, gain_step, gain_ramp;
    logic signed [AccW-1:0] acc_shifted;
    logic [SIGWIDTH-1:0]    clipped;

    // Move toward the target by at most Step, never past it.
    always_comb begin
        if (gain_target_i > gain_q) begin
            gain_diff = gain_target_i - gain_q;
            gain_step = (gain_diff < Step) ? gain_diff : Step;
            gain_ramp = gain_q + gain_step;
        end else begin
            gain_diff = gain_q - gain_target_i;
            gain_step = (gain_diff < Step) ? gain_diff : Step;
            gain_ramp = gain_q - gain_step;
        end
    end

    assign acc_shifted = acc_q >>> GAINFRAC;

    sat_clip #(
        .IN_WIDTH(AccW),
        .SIGWIDTH(SIGWIDTH)
    ) u_sat_clip (
        .val_i(acc_shifted),
        .val_o(clipped)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mult_d    = mult_q;
        gain_d    = gain_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q | (sample_clk_i && (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                if (sample_clk_i) begin
                    state_d = StMult;
                    cnt_d   = '0;
                    acc_d   = '0;
                    mcand_d = {{(AccW - SIGWIDTH){sample_in_i[SIGWIDTH-1]}}, sample_in_i};
                    // Bypass multiplies by unity so latency matches the gain path.
                    if (mode_i) begin
                        gain_d = gain_ramp;
                        mult_d = gain_ramp;
                    end else begin
                        mult_d = Unity;
                    end
                end
            end
            StMult: begin
                // One trailing cycle after the last bit keeps latency at GAINWIDTH+2.
                if (cnt_q == CntW'(GAINWIDTH)) begin
                    state_d = StSat;
                end else begin
                    if (mult_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d = mcand_q <<< 1;
                    mult_d  = mult_q >> 1;
                    cnt_d   = cnt_q + CntW'(1);
                end
            end
            StSat: begin
                out_d   = clipped;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mult_q    <= '0;
            gain_q    <= Unity;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mult_q    <= mult_d;
            gain_q    <= gain_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample_out_o   = out_q;
    assign sample_valid_o = valid_q;
    assign busy_o         = (state_q != StIdle);
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_drive_gain.sv
// Randomized and directed bench for drive_gain against an arithmetic reference model.
module tb_drive_gain;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_clk = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] gain_target = 8'd0;
    logic [7:0] sample_in = 8'd0;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic       busy;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_gain = 16;
    int m_overrun = 0;

    drive_gain #(
        .SIGWIDTH(8),
        .GAINWIDTH(8),
        .GAINFRAC(4),
        .RAMPSTEP(1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .sample_clk_i(sample_clk),
        .mode_i(mode),
        .gain_target_i(gain_target),
        .sample_in_i(sample_in),
        .sample_out_o(sample_out),
        .sample_valid_o(sample_valid),
        .busy_o(busy),
        .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_result(input int x, input int g);
        int r;
        r = (x * g) >>> 4;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        sample_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_gain = 16;
        m_overrun = 0;
        check_eq("rst_out", int'($signed(sample_out)), 0);
        check_eq("rst_valid", int'(sample_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_overrun", int'(overrun), 0);
        check_eq("rst_gain", int'(dut.gain_q), 16);
    endtask

    // inj in 1..10 pulses sample_clk (with sample 99) so it is sampled inj edges after capture.
    task automatic do_sample(input int x, input bit md, input int tgt, input int inj);
        logic [7:0] xb;
        logic [7:0] tb8;
        int         g;
        int         exp_out;
        xb  = x[7:0];
        tb8 = tgt[7:0];
        @(negedge clk);
        sample_clk  = 1'b1;
        mode        = md;
        gain_target = tb8;
        sample_in   = xb;
        @(posedge clk);
        #1;
        sample_clk  = 1'b0;
        mode        = 1'($urandom);
        gain_target = 8'($urandom);
        sample_in   = 8'($urandom);
        if (md) begin
            if (tgt > m_gain) m_gain = m_gain + 1;
            else if (tgt < m_gain) m_gain = m_gain - 1;
        end
        g = md ? m_gain : 16;
        exp_out = model_result(int'($signed(xb)), g);
        for (int k = 1; k <= 10; k++) begin
            if (k == inj) begin
                sample_clk = 1'b1;
                sample_in  = 8'd99;
            end
            @(posedge clk);
            #1;
            sample_clk = 1'b0;
            if (k == inj) m_overrun = 1;
            check_eq("busy", int'(busy), (k < 10) ? 1 : 0);
            check_eq("valid", int'(sample_valid), (k == 10) ? 1 : 0);
        end
        check_eq("out", int'($signed(sample_out)), exp_out);
        check_eq("gain", int'(dut.gain_q), m_gain);
        check_eq("overrun", int'(overrun), m_overrun);
        @(posedge clk);
        #1;
        check_eq("valid_drop", int'(sample_valid), 0);
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        sample_clk  = 1'b1;
        mode        = 1'b1;
        gain_target = 8'd200;
        sample_in   = 8'd60;
        @(posedge clk);
        #1;
        sample_clk = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check_eq("pre_rst_valid", int'(sample_valid), 0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_gain = 16;
        m_overrun = 0;
        check_eq("mid_rst_out", int'($signed(sample_out)), 0);
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_gain", int'(dut.gain_q), 16);
        for (int k = 0; k < 8; k++) begin
            check_eq("mid_rst_valid", int'(sample_valid), 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int         x;
        int         tgt;
        int         inj;
        bit         md;
        logic [7:0] rb;

        do_reset();

        // Unity gain
        do_sample(50, 1'b1, 16, 0);

        // Ramp 16 -> 32 then hold, then on to 64 for saturation
        do_reset();
        for (int i = 0; i < 20; i++) do_sample(40, 1'b1, 32, 0);
        for (int i = 0; i < 32; i++) do_sample(10, 1'b1, 64, 0);
        do_sample(100, 1'b1, 64, 0);
        do_sample(-100, 1'b1, 64, 0);

        // Floor rounding at gain 24
        do_reset();
        for (int i = 0; i < 8; i++) do_sample(0, 1'b1, 24, 0);
        do_sample(-3, 1'b1, 24, 0);

        // Bypass freezes gain
        for (int i = 0; i < 5; i++) do_sample(-77, 1'b0, 64, 0);

        // Overrun mid-multiply, then sticky across later samples
        do_sample(33, 1'b1, 24, 3);
        do_sample(-20, 1'b1, 24, 0);
        do_sample(5, 1'b0, 24, 0);

        // Overrun on the edge busy drops
        do_reset();
        do_sample(70, 1'b1, 16, 10);

        // Reset during multiply, then a clean capture
        do_reset_mid();
        do_sample(50, 1'b1, 16, 0);

        // Gain 0 gives 0
        do_reset();
        for (int i = 0; i < 17; i++) do_sample(127, 1'b1, 0, 0);

        // Max gain with full-scale inputs
        do_reset();
        for (int i = 0; i < 239; i++) do_sample(1, 1'b1, 255, 0);
        do_sample(127, 1'b1, 255, 0);
        do_sample(-128, 1'b1, 255, 0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 120; i++) begin
            rb  = 8'($urandom);
            x   = int'($signed(rb));
            md  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: tgt = 0;
                1: tgt = 255;
                default: tgt = $urandom_range(0, 255);
            endcase
            inj = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 10) : 0;
            do_sample(x, md, tgt, inj);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
